hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RV32IM core. Generates the per-stage write-enable and flush strobes that drive the F/D, D/X and X/M pipeline latches and the PC register: load-use stalls, taken-branch squashes, and multi-cycle mul/div holds. Sits beside the datapath and sees the decode- and execute-stage instruction words, the execute-stage branch resolution and the mul/div unit handshake.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 48 ++++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 opcode constants and hazard controller state type
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MD_WAIT = 2'd1;

    typedef enum logic [1:0] {
        RUN     = S_RUN,
        MD_WAIT = S_MD_WAIT
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - decodes register fields and flags load-use and mul/div hazards
import riscv_pkg::*;

module hazard_detect (
    input  logic [31:0] d_insn,
    input  logic [31:0] x_insn,
    output logic        load_use,
    output logic        is_muldiv
);

    logic [6:0] d_op;
    logic [6:0] x_op;
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic [4:0] x_rd;
    logic       d_rs1_used;
    logic       d_rs2_used;
    logic       unused_bits;

    assign d_op  = d_insn[6:0];
    assign d_rs1 = d_insn[19:15];
    assign d_rs2 = d_insn[24:20];
    assign x_op  = x_insn[6:0];
    assign x_rd  = x_insn[11:7];

    // Only formats that actually read a register field may create a dependency.
    always_comb begin
        d_rs1_used = 1'b0;
        d_rs2_used = 1'b0;
        case (d_op)
            OP_R, OP_STORE, OP_BRANCH: begin
                d_rs1_used = 1'b1;
                d_rs2_used = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: d_rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign is_muldiv = (x_op == OP_R) && (x_insn[31:25] == FUNCT7_MULDIV);

    assign load_use = (x_op == OP_LOAD) && (x_rd != 5'd0) &&
                      ((d_rs1_used && (d_rs1 == x_rd)) ||
                       (d_rs2_used && (d_rs2 == x_rd)));

    assign unused_bits = ^{d_insn[31:25], d_insn[14:7], x_insn[24:12]};

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencing; HAZARD_PERF_EN adds perf counters
import riscv_pkg::*;

module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d_insn,
    input  logic [31:0] x_insn,
    input  logic        x_br_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        fd_flush,
    output logic        dx_we,
    output logic        dx_flush,
    output logic        xm_bubble,
    output logic        md_start,
    output logic        md_timeout,
    output logic        stall
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    ctrl_state_t      state;
    logic [CNT_W-1:0] md_cnt;
    logic             load_use;
    logic             is_muldiv;
    logic             md_release;

    hazard_detect u_detect (
        .d_insn    (d_insn),
        .x_insn    (x_insn),
        .load_use  (load_use),
        .is_muldiv (is_muldiv)
    );

    assign md_release = md_ready || (md_cnt == CNT_LAST);

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_bubble = 1'b0;
        md_start  = 1'b0;
        case (state)
            RUN: begin
                if (is_muldiv) begin
                    md_start  = 1'b1;
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_bubble = 1'b1;
                end else if (x_br_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (load_use) begin
                    pc_we    = 1'b0;
                    fd_we    = 1'b0;
                    dx_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                // The release cycle itself lets the whole pipe advance.
                if (!md_release) begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_bubble = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign stall = !pc_we;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (is_muldiv) begin
                        state  <= MD_WAIT;
                        md_cnt <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_ready) begin
                        state <= RUN;
                    end else if (md_cnt == CNT_LAST) begin
                        state      <= RUN;
                        md_timeout <= 1'b1;
                    end else begin
                        md_cnt <= md_cnt + CNT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (fd_flush && (perf_flush_cnt != 16'hFFFF))
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random checks of hazard_ctrl against a reference model
module tb_hazard_ctrl;

    localparam int MD_TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] d_insn = 32'h00000013;
    logic [31:0] x_insn = 32'h00000013;
    logic        x_br_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_bubble, md_start, md_timeout, stall;
`ifdef HAZARD_PERF_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

    hazard_ctrl #(.MD_TIMEOUT(MD_TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .d_insn     (d_insn),
        .x_insn     (x_insn),
        .x_br_taken (x_br_taken),
        .md_ready   (md_ready),
        .pc_we      (pc_we),
        .fd_we      (fd_we),
        .fd_flush   (fd_flush),
        .dx_we      (dx_we),
        .dx_flush   (dx_flush),
        .xm_bubble  (xm_bubble),
        .md_start   (md_start),
        .md_timeout (md_timeout),
        .stall      (stall)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference model: pending mul/div, wait cycles completed, sticky timeout, perf tallies
    bit m_wait;
    int m_done;
    bit m_to;
    int m_stalls;
    int m_flushes;

    localparam logic [31:0] NOP = 32'h00000013;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd, input logic [6:0] op);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_i(input int rs1, input int rd, input logic [6:0] op);
        return {12'h004, 5'(rs1), 3'b010, 5'(rd), op};
    endfunction

    function automatic bit is_md(input logic [31:0] i);
        return (i[6:0] == 7'h33) && (i[31:25] == 7'h01);
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit load_hazard(input logic [31:0] x, input logic [31:0] d);
        if (x[6:0] != 7'h03 || x[11:7] == 5'd0) return 1'b0;
        return (reads_rs1(d[6:0]) && d[19:15] == x[11:7]) ||
               (reads_rs2(d[6:0]) && d[24:20] == x[11:7]);
    endfunction

    // {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_bubble, md_start, md_timeout, stall}
    function automatic logic [8:0] predict();
        bit pc = 1, fd = 1, ff = 0, dx = 1, df = 0, xb = 0, st = 0;
        if (!m_wait) begin
            if (is_md(x_insn)) begin
                pc = 0; fd = 0; dx = 0; xb = 1; st = 1;
            end else if (x_br_taken) begin
                ff = 1; df = 1;
            end else if (load_hazard(x_insn, d_insn)) begin
                pc = 0; fd = 0; df = 1;
            end
        end else if (!(md_ready || (m_done + 1 == MD_TO))) begin
            pc = 0; fd = 0; dx = 0; xb = 1;
        end
        return {pc, fd, ff, dx, df, xb, st, m_to, !pc};
    endfunction

    task automatic check_sig(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        check_sig(tag, {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_bubble, md_start, md_timeout, stall},
                  predict());
    endtask

    task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_EN
        total++;
        assert (perf_stall_cnt === 16'(m_stalls) && perf_flush_cnt === 16'(m_flushes)) else begin
            bad++;
            $error("FAIL %s observed=%0d/%0d expected=%0d/%0d", tag,
                   perf_stall_cnt, perf_flush_cnt, m_stalls, m_flushes);
        end
`else
        if (tag.len() == 0) $display("perf counters absent");
`endif
    endtask

    task automatic model_reset();
        m_wait = 0; m_done = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic advance();
        logic [8:0] e;
        if (reset) return;
        e = predict();
        if (e[0] && m_stalls < 65535) m_stalls++;
        if (e[6] && m_flushes < 65535) m_flushes++;
        if (!m_wait) begin
            if (is_md(x_insn)) begin
                m_wait = 1; m_done = 0;
            end
        end else if (md_ready) begin
            m_wait = 0;
        end else if (m_done + 1 == MD_TO) begin
            m_wait = 0; m_to = 1;
        end else begin
            m_done++;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        check_now(tag);
        @(negedge clock);
        advance();
        #1;
    endtask

    function automatic logic [31:0] rand_insn(input bit for_exec);
        int k = $urandom_range(0, 7);
        int a = $urandom_range(0, 7);
        int b = $urandom_range(0, 7);
        int c = $urandom_range(0, 7);
        case (k)
            0, 1:    return enc_i(a, b, 7'h03);
            2:       return for_exec ? enc_r(7'h01, a, b, 3'($urandom_range(0, 7)), c, 7'h33)
                                     : {20'h12345, 5'(c), 7'h37};
            3:       return enc_r(7'h00, a, b, 3'b000, c, 7'h33);
            4:       return enc_i(a, b, 7'h13);
            5:       return enc_r(7'h00, a, b, 3'b010, 0, 7'h23);
            6:       return enc_r(7'h00, a, b, 3'b000, 0, 7'h63);
            default: return enc_i(a, c, 7'h67);
        endcase
    endfunction

    initial begin
        logic [31:0] lw_x5, lw_x0, add_dep, add_x0, mul_x7;
        lw_x5   = enc_i(1, 5, 7'h03);
        lw_x0   = enc_i(1, 0, 7'h03);
        add_dep = enc_r(7'h00, 2, 5, 3'b000, 6, 7'h33);
        add_x0  = enc_r(7'h00, 2, 0, 3'b000, 6, 7'h33);
        mul_x7  = enc_r(7'h01, 2, 1, 3'b000, 7, 7'h33);

        model_reset();
        #2;
        check_now("reset_state");
        check_perf("reset_perf");
        @(negedge clock);
        #1;
        reset = 1'b0;

        // Load followed by dependent add: one stall cycle, then the bubble moves on
        x_insn = lw_x5; d_insn = add_dep;
        #1 check_sig("ld_use_direct", 9'({pc_we, fd_we, dx_flush}), 9'b001);
        step("ld_use");
        x_insn = NOP;
        step("ld_use_after");

        x_insn = lw_x0; d_insn = add_x0;
        #1 check_sig("ld_x0_direct", 9'(stall), 9'b0);
        step("ld_x0");

        x_insn = lw_x5; d_insn = add_dep; x_br_taken = 1'b1;
        #1 check_sig("br_over_ld_direct", 9'({pc_we, fd_flush, dx_flush, stall}), 9'b1110);
        step("br_over_ld");
        x_br_taken = 1'b0; x_insn = NOP; d_insn = NOP;
        step("after_br");

        // mul with md_ready on the third wait cycle; branch must be ignored while waiting
        x_insn = mul_x7; d_insn = add_dep;
        #1 check_sig("md_issue_direct", 9'({md_start, xm_bubble, pc_we}), 9'b110);
        step("md_issue");
        x_br_taken = 1'b1;
        step("md_wait1");
        x_br_taken = 1'b0;
        step("md_wait2");
        md_ready = 1'b1;
        #1 check_sig("md_release_direct", 9'({pc_we, fd_we, dx_we, xm_bubble, md_start}), 9'b11100);
        step("md_wait3_release");
        md_ready = 1'b0; x_insn = NOP;
        step("md_after");

        // md_ready never arrives: forced release on the MD_TO-th wait cycle
        x_insn = mul_x7;
        step("to_issue");
        for (int i = 1; i <= MD_TO; i++) step($sformatf("to_wait%0d", i));
        x_insn = NOP;
        #1 check_sig("to_sticky_direct", 9'(md_timeout), 9'b1);
        step("to_after1");
        step("to_after2");

        // Reset in the middle of a wait
        x_insn = mul_x7;
        step("rst_issue");
        step("rst_wait1");
        x_insn = NOP; reset = 1'b1;
        #1;
        model_reset();
        check_now("rst_mid_wait");
        check_sig("rst_to_clear", 9'(md_timeout), 9'b0);
        check_perf("rst_perf");
        @(negedge clock);
        #1;
        reset = 1'b0;
        step("rst_after");

        for (int n = 0; n < 400; n++) begin
            if (!m_wait) x_insn = rand_insn(1'b1);
            d_insn = rand_insn(1'b0);
            x_br_taken = ($urandom_range(0, 3) == 0);
            md_ready = ($urandom_range(0, 2) == 0);
            step("random");
        end
        check_perf("final_perf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
